// File: rtl/stream_map_addk_pkg.sv
// Shared definitions for the valid/ready stream blocks: mode encodings,
// reset constant and the default element width.
package stream_map_addk_pkg;

  // Default element width, matching intN (int8 for the stock build)
  localparam int N_DEF = 8;

  // Reset constant; with MODE_WRAP this reproduces the original map-add1 block
  localparam int K_RST = 1;

  typedef enum logic [1:0] {
    MODE_WRAP = 2'b00,
    MODE_USAT = 2'b01,
    MODE_SSAT = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

endpackage

// File: rtl/stream_fifo.sv
// Parametrised W x DEPTH synchronous FIFO with push/pop/full/empty.
// Pointers carry one extra wrap bit so full and empty are unambiguous.
module stream_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         push,
  input  logic [W-1:0] wr_data,
  input  logic         pop,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         push_ok;
  logic         pop_ok;

  always_comb begin
    full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    empty    = (wr_ptr_q == rd_ptr_q);
    push_ok  = push && !full;
    pop_ok   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is not reset: the pointers alone decide what is visible
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/stream_map_addk.sv
// Stream block adding a configurable constant K to each element (wrap,
// unsigned or signed saturation), buffered through a FIFO, with an output counter.
module stream_map_addk
  import stream_map_addk_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int DEPTH   = 4,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N-1:0]       in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N-1:0]       out_data,
  input  logic               cfg_load,
  input  logic [N-1:0]       cfg_k,
  input  logic [1:0]         cfg_mode,
  output logic               cfg_err,
  output logic [COUNT_W-1:0] count
);

  function automatic logic [N-1:0] sat_unsigned(input logic [N:0] usum);
    sat_unsigned = usum[N] ? {N{1'b1}} : usum[N-1:0];
  endfunction

  // Overflow only when both operands share a sign that the result lacks
  function automatic logic [N-1:0] sat_signed(input logic [N-1:0] x, input logic [N-1:0] k);
    logic signed [N-1:0] sx;
    logic signed [N-1:0] sk;
    logic signed [N-1:0] ssum;
    sx   = x;
    sk   = k;
    ssum = sx + sk;
    if ((sx[N-1] == sk[N-1]) && (ssum[N-1] != sx[N-1]))
      sat_signed = sx[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    else
      sat_signed = ssum;
  endfunction

  function automatic logic [N-1:0] map_addk(input logic [N-1:0] x, input logic [N-1:0] k,
                                            input mode_e m);
    logic [N:0] usum;
    usum = {1'b0, x} + {1'b0, k};
    case (m)
      MODE_USAT: map_addk = sat_unsigned(usum);
      MODE_SSAT: map_addk = sat_signed(x, k);
      default:   map_addk = usum[N-1:0];
    endcase
  endfunction

  logic [N-1:0]       k_q, k_d;
  mode_e              mode_q, mode_d;
  logic               cfg_err_q, cfg_err_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               rdy_q, rdy_d;

  logic               full, empty;
  logic [N-1:0]       rd_data;
  logic [N-1:0]       f_val;
  logic               push, pop, cfg_ok;

  always_comb begin
    in_ready  = rdy_q && !full;
    out_valid = !empty;
    out_data  = empty ? '0 : rd_data;
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
    f_val     = map_addk(in_data, k_q, mode_q);

    // A push in the same cycle always beats a configuration load
    cfg_ok    = cfg_load && empty && !push;
    k_d       = k_q;
    mode_d    = mode_q;
    if (cfg_ok) begin
      k_d    = cfg_k;
      mode_d = mode_e'(cfg_mode);
    end
    cfg_err_d = cfg_load && !cfg_ok;

    count_d   = count_q;
    if (pop) count_d = count_q + COUNT_W'(1);
    rdy_d     = 1'b1;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      k_q       <= N'(K_RST);
      mode_q    <= MODE_WRAP;
      cfg_err_q <= 1'b0;
      count_q   <= '0;
      rdy_q     <= 1'b0;
    end else begin
      k_q       <= k_d;
      mode_q    <= mode_d;
      cfg_err_q <= cfg_err_d;
      count_q   <= count_d;
      rdy_q     <= rdy_d;
    end
  end

  assign cfg_err = cfg_err_q;
  assign count   = count_q;

  stream_fifo #(
    .W     (N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .nrst    (nrst),
    .push    (push),
    .wr_data (f_val),
    .pop     (pop),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty)
  );

endmodule
